// File: rtl/router_pkg.sv
// Router-wide constants: flit width and the flit-type field shared by the
// input and output flow controllers.
package router_pkg;

    localparam int unsigned DW = 32;

    // Flit-type field position inside a flit
    localparam int unsigned FT_MSB = 30;
    localparam int unsigned FT_LSB = 29;

    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_BODY = 2'b00;
    localparam logic [1:0] FT_TAIL = 2'b10;
    localparam logic [1:0] FT_NULL = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } pkt_state_e;

endpackage

// File: rtl/ofc_skid_buf.sv
// Two-entry output skid buffer; entry 0 is the head presented downstream.
module ofc_skid_buf #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         head_valid,
    output logic [1:0]   occ
);

    logic [W-1:0] ent0_q, ent1_q;
    logic         v0_q, v1_q;

    // v1_q is only ever set while v0_q is set, so the head is always entry 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (!v0_q) begin
                        ent0_q <= push_data;
                        v0_q   <= 1'b1;
                    end else begin
                        ent1_q <= push_data;
                        v1_q   <= 1'b1;
                    end
                end
                2'b01: begin
                    if (v1_q) begin
                        ent0_q <= ent1_q;
                        v1_q   <= 1'b0;
                    end else begin
                        ent0_q <= '0;
                        v0_q   <= 1'b0;
                    end
                end
                2'b11: begin
                    if (v1_q) begin
                        ent0_q <= ent1_q;
                        ent1_q <= push_data;
                    end else begin
                        ent0_q <= push_data;
                        v0_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data  = ent0_q;
    assign head_valid = v0_q;
    assign occ        = 2'(v0_q) + 2'(v1_q);

endmodule

// File: rtl/ofc.sv
// Output flow controller: drains the output-VC FIFO into the downstream link,
// strips null flits, polices packet framing, counts packets and flags stalls.
module ofc #(
    parameter int unsigned DW        = router_pkg::DW,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned STALL_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic [DW-1:0]    data_out,
    output logic             out_val,
    input  logic             data_out_req,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             proto_err,
    output logic             stall
);

    localparam int unsigned SCW = 16;

    router_pkg::pkt_state_e state_q, state_d;

    logic       transfer_c;
    logic       enq_c;
    logic       err_set_c;
    logic [1:0] occ;
    logic [1:0] ftype_c;
    logic [1:0] out_type_c;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;

    assign transfer_c = out_val & data_out_req;
    assign fifo_rd_en = ~fifo_empty & ~rst & ((occ < 2'd2) | transfer_c);
    assign ftype_c    = fifo_data[router_pkg::FT_MSB:router_pkg::FT_LSB];
    assign out_type_c = data_out[router_pkg::FT_MSB:router_pkg::FT_LSB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= router_pkg::ST_IDLE;
        else     state_q <= state_d;
    end

    // Framing FSM: advances only on popped non-null flits
    always_comb begin
        state_d   = state_q;
        enq_c     = 1'b0;
        err_set_c = 1'b0;
        if (fifo_rd_en && (ftype_c != router_pkg::FT_NULL)) begin
            case (state_q)
                router_pkg::ST_IDLE: begin
                    if (ftype_c == router_pkg::FT_HEAD) begin
                        state_d = router_pkg::ST_PKT;
                        enq_c   = 1'b1;
                    end else begin
                        err_set_c = 1'b1;
                    end
                end
                router_pkg::ST_PKT: begin
                    enq_c = 1'b1;
                    if (ftype_c == router_pkg::FT_TAIL) state_d = router_pkg::ST_IDLE;
                    if (ftype_c == router_pkg::FT_HEAD) err_set_c = 1'b1;
                end
                default: state_d = router_pkg::ST_IDLE;
            endcase
        end
    end

    ofc_skid_buf #(
        .W (DW)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (enq_c),
        .push_data  (fifo_data),
        .pop        (transfer_c),
        .head_data  (data_out),
        .head_valid (out_val),
        .occ        (occ)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt   <= '0;
            proto_err <= 1'b0;
        end else begin
            if (transfer_c && (out_type_c == router_pkg::FT_TAIL))
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            if (err_set_c)
                proto_err <= 1'b1;
        end
    end

    // Blocked-cycle counter, saturating; cleared by a transfer or an empty link
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!out_val || transfer_c)
            stall_cnt_d = '0;
        else if (stall_cnt_q < SCW'(STALL_MAX))
            stall_cnt_d = stall_cnt_q + SCW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            stall       <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall       <= (stall_cnt_d == SCW'(STALL_MAX));
        end
    end

endmodule

// File: tb/tb_ofc.sv
// Scoreboard bench for ofc: a FIFO model feeds the DUT, a packet-rule model
// predicts transmitted flits, and a monitor checks every link cycle.
module tb_ofc;
    import router_pkg::*;

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned STALL_MAX = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    fifo_data;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [DW-1:0]    data_out;
    logic             out_val;
    logic             data_out_req;
    logic [CNT_W-1:0] pkt_cnt;
    logic             proto_err;
    logic             stall;

    ofc #(
        .DW        (DW),
        .CNT_W     (CNT_W),
        .STALL_MAX (STALL_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .data_out     (data_out),
        .out_val      (out_val),
        .data_out_req (data_out_req),
        .pkt_cnt      (pkt_cnt),
        .proto_err    (proto_err),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    logic [DW-1:0]    fifoq[$];
    logic [DW-1:0]    scb[$];
    bit               in_pkt;
    bit               err_m;
    bit               err_seen;
    int               occ_seen;
    logic [CNT_W-1:0] exp_pkt;
    int               blk;
    int               pops;
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [1:0] t);
        logic [DW-1:0] w;
        w = $urandom;
        w[FT_MSB:FT_LSB] = t;
        return w;
    endfunction

    // Packet rules: what the link should carry for each popped FIFO word
    task automatic model_pop(input logic [DW-1:0] w);
        logic [1:0] t;
        t = w[FT_MSB:FT_LSB];
        if (t == FT_NULL) return;
        if (!in_pkt) begin
            if (t == FT_HEAD) begin
                in_pkt = 1'b1;
                scb.push_back(w);
            end else begin
                err_m = 1'b1;
            end
        end else begin
            scb.push_back(w);
            if (t == FT_TAIL) in_pkt = 1'b0;
            if (t == FT_HEAD) err_m = 1'b1;
        end
    endtask

    task automatic cycle(input bit req, input bit gap);
        bit exp_rd;
        @(negedge clk);
        data_out_req = req;
        fifo_empty   = gap || (fifoq.size() == 0);
        fifo_data    = (fifoq.size() != 0) ? fifoq[0] : '0;
        #1;
        occ_seen = scb.size();
        err_seen = err_m;
        exp_rd = !rst && !fifo_empty && (occ_seen < 2 || (occ_seen > 0 && req));
        chk("rd_en", 64'(fifo_rd_en), 64'(exp_rd));
        if (fifo_rd_en && !fifo_empty) begin
            pops++;
            model_pop(fifoq.pop_front());
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((fifoq.size() != 0 || scb.size() != 0) && n < 100) begin
            cycle(1'b1, 1'b0);
            n++;
        end
        cycle(1'b1, 1'b0);
        chk("drain_timeout", 64'(fifoq.size() + scb.size()), 64'd0);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst          = 1'b1;
        fifo_empty   = 1'b1;
        data_out_req = 1'b0;
        #1;
        chk("rst_out_val", 64'(out_val), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        fifoq.delete();
        scb.delete();
        in_pkt   = 1'b0;
        err_m    = 1'b0;
        err_seen = 1'b0;
        occ_seen = 0;
        exp_pkt  = '0;
        blk      = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: checks link outputs against the scoreboard every cycle
    initial begin
        logic [DW-1:0] w;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("out_val", 64'(out_val), 64'(occ_seen > 0));
                chk("stall", 64'(stall), 64'(blk >= int'(STALL_MAX)));
                chk("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
                chk("proto_err", 64'(proto_err), 64'(err_seen));
                if (out_val && data_out_req) begin
                    if (scb.size() == 0) begin
                        chk("unexpected_flit", 64'(data_out), 64'hDEAD);
                    end else begin
                        w = scb.pop_front();
                        chk("data_out", 64'(data_out), 64'(w));
                        if (w[FT_MSB:FT_LSB] == FT_TAIL) exp_pkt = exp_pkt + 1'b1;
                    end
                end
                if (occ_seen > 0 && !data_out_req) blk++;
                else                               blk = 0;
            end
        end
    end

    initial begin
        rst          = 1'b0;
        fifo_empty   = 1'b1;
        fifo_data    = '0;
        data_out_req = 1'b0;
        in_pkt = 1'b0; err_m = 1'b0; err_seen = 1'b0;
        occ_seen = 0; exp_pkt = '0; blk = 0; pops = 0;
        #2;
        rst_pulse();

        // Basic packet at full rate
        fifoq.push_back(32'h2000_0001);
        fifoq.push_back(32'h0000_0002);
        fifoq.push_back(32'h4000_0003);
        drain();
        chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
        chk("t1_proto_err", 64'(proto_err), 64'd0);

        // Backpressure: only two pops fit while blocked
        fifoq.push_back(32'h2000_0001);
        fifoq.push_back(32'h0000_0002);
        fifoq.push_back(32'h4000_0003);
        pops = 0;
        repeat (6) cycle(1'b0, 1'b0);
        chk("t2_pops", 64'(pops), 64'd2);
        chk("t2_hold", 64'(data_out), 64'h2000_0001);
        drain();
        chk("t2_pkt_cnt", 64'(pkt_cnt), 64'd2);

        // Null flit inside a packet
        fifoq.push_back(32'h2000_0011);
        fifoq.push_back(32'h6000_00FF);
        fifoq.push_back(32'h4000_0013);
        drain();
        chk("t3_pkt_cnt", 64'(pkt_cnt), 64'd3);

        // Stray body in IDLE, then a good packet
        fifoq.push_back(32'h0000_0009);
        fifoq.push_back(32'h2000_0021);
        fifoq.push_back(32'h4000_0022);
        drain();
        chk("t4_proto_err", 64'(proto_err), 64'd1);
        chk("t4_pkt_cnt", 64'(pkt_cnt), 64'd4);

        // Stall detection and release
        fifoq.push_back(32'h2000_0031);
        fifoq.push_back(32'h4000_0032);
        repeat (6) cycle(1'b0, 1'b0);
        chk("t5_stall_hi", 64'(stall), 64'd1);
        drain();
        chk("t5_stall_lo", 64'(stall), 64'd0);
        chk("t5_pkt_cnt", 64'(pkt_cnt), 64'd5);

        // Reset mid-packet with two flits buffered
        fifoq.push_back(32'h2000_0041);
        fifoq.push_back(32'h0000_0042);
        fifoq.push_back(32'h4000_0043);
        repeat (3) cycle(1'b0, 1'b0);
        rst_pulse();
        fifoq.push_back(32'h0000_0009);
        fifoq.push_back(32'h2000_0051);
        fifoq.push_back(32'h4000_0052);
        drain();
        chk("t6_proto_err", 64'(proto_err), 64'd1);
        chk("t6_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // Randomized traffic: nulls, framing errors, backpressure, FIFO gaps
        for (int i = 0; i < 1500; i++) begin
            if (fifoq.size() < 4) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r == 0)      fifoq.push_back(mk(($urandom_range(0, 1) != 0) ? FT_BODY : FT_TAIL));
                else if (r == 1) fifoq.push_back(mk(FT_NULL));
                else begin
                    fifoq.push_back(mk(FT_HEAD));
                    for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
                        if ($urandom_range(0, 7) == 0) fifoq.push_back(mk(FT_NULL));
                        if ($urandom_range(0, 15) == 0) fifoq.push_back(mk(FT_HEAD));
                        fifoq.push_back(mk(FT_BODY));
                    end
                    fifoq.push_back(mk(FT_TAIL));
                end
            end
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
